// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Core-side request/response and memory-macro signals of the arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = mem_arb_pkg::AW_DEF,
  parameter int unsigned DW = mem_arb_pkg::DW_DEF
) ();

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          d_err;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport arb (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport core (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, d_err
  );

  modport mem (
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data with a saturating starvation counter
// that forces a fetch grant after STARVE_MAX consecutive data grants.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic arb_en_i,
  output logic if_win_o,
  output logic d_win_o
);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             at_max;

  always_comb begin
    starve_d = starve_q;
    at_max   = (starve_q == CNT_W'(STARVE_MAX));
    d_win_o  = arb_en_i & d_req_i & ~(at_max & if_req_i);
    if_win_o = arb_en_i & if_req_i & ~d_win_o;
    // Only data grants made while fetch is waiting count toward starvation.
    if (if_win_o) begin
      starve_d = '0;
    end else if (d_win_o) begin
      if (!if_req_i) begin
        starve_d = '0;
      end else if (!at_max) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory between fetch and load/store, one access in flight.
// Optional: define MEM_ARB_MISALIGN_CHECK_EN to reject misaligned data accesses with d_err.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = AW_DEF,
  parameter int unsigned DW         = DW_DEF,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.arb bus
);

  state_e           state_q, state_d;
  owner_e           owner_q;
  logic [CNT_W-1:0] lat_q, lat_d;
  logic [AW-1:0]    addr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    if_rdata_q;
  logic [DW-1:0]    d_rdata_q;
  logic             we_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic             if_rvalid_q;
  logic             d_rvalid_q;
  logic             arb_en;
  logic             if_win;
  logic             d_win;
  logic             gnt_any;
  logic             capture;
  logic             misal_d;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  logic             misal_q;
  logic             d_err_q;
  logic             err_rsp;
`endif

  // Grants are only offered while idle or while the previous response is on the bus.
  assign arb_en  = (state_q == IDLE) | (state_q == RESP);
  assign gnt_any = if_win | d_win;

`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign misal_d = d_win & (bus.d_addr[1:0] != 2'b00);
`else
  assign misal_d = 1'b0;
`endif

  mem_arb_pick #(
    .STARVE_MAX (STARVE_MAX)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .if_req_i (bus.if_req),
    .d_req_i  (bus.d_req),
    .arb_en_i (arb_en & ~rst),
    .if_win_o (if_win),
    .d_win_o  (d_win)
  );

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    capture = 1'b0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
    err_rsp = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (gnt_any) state_d = ISSUE;
      end
      ISSUE: begin
        lat_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
        if (misal_q) begin
          state_d = RESP;
          err_rsp = 1'b1;
        end
`endif
      end
      WAIT: begin
        // Counter reaching zero marks the cycle mem_rdata is valid.
        if (lat_q == '0) begin
          capture = 1'b1;
          state_d = RESP;
        end else begin
          lat_d = lat_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = gnt_any ? ISSUE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      lat_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      misal_q     <= 1'b0;
      d_err_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      if_rvalid_q <= 1'b0;
      d_rvalid_q  <= 1'b0;
      if (gnt_any) begin
        owner_q  <= d_win ? OWN_D : OWN_IF;
        addr_q   <= d_win ? bus.d_addr : bus.if_addr;
        we_q     <= d_win & bus.d_we;
        wdata_q  <= d_win ? bus.d_wdata : '0;
        mem_en_q <= ~misal_d;
        mem_we_q <= d_win & bus.d_we & ~misal_d;
      end
      if (capture) begin
        if (owner_q == OWN_D) begin
          d_rvalid_q <= 1'b1;
          d_rdata_q  <= we_q ? '0 : bus.mem_rdata;
        end else begin
          if_rvalid_q <= 1'b1;
          if_rdata_q  <= bus.mem_rdata;
        end
      end
`ifdef MEM_ARB_MISALIGN_CHECK_EN
      d_err_q <= 1'b0;
      if (gnt_any) misal_q <= misal_d;
      if (err_rsp) begin
        d_rvalid_q <= 1'b1;
        d_rdata_q  <= '0;
        d_err_q    <= 1'b1;
      end
`endif
    end
  end

  assign bus.if_gnt    = if_win;
  assign bus.d_gnt     = d_win;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q;
  assign bus.d_rdata   = d_rdata_q;
`ifdef MEM_ARB_MISALIGN_CHECK_EN
  assign bus.d_err     = d_err_q;
`else
  assign bus.d_err     = 1'b0;
`endif
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule
